data_word_access_ctrl: RTL and testbench

//  Initiator side of the data word memory port. Accepts load/store requests from a logic core,

---
 rtl/data_word_access_ctrl_pkg.sv | 24 ++
 rtl/dmem_bit_merge.sv | 21 ++
 rtl/data_word_access_ctrl.sv | 170 +++++++++++++++++
 tb/tb_data_word_access_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/data_word_access_ctrl_pkg.sv
// Shared definitions for the data word access controller: command codes, FSM
// state encodings and default geometry.
package data_word_access_ctrl_pkg;

  localparam int AW_DEF    = 16;
  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 4096;

  typedef enum logic [1:0] {
    CMD_RDW = 2'b00,
    CMD_WRW = 2'b01,
    CMD_RDB = 2'b10,
    CMD_WRB = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD_A = 3'd2,
    ST_RD_D = 3'd3,
    ST_RSP  = 3'd4
  } state_e;

endpackage

// File: rtl/dmem_bit_merge.sv
// Combinational bit merge/extract: replaces one bit of a word and returns the
// original value of that bit.
module dmem_bit_merge #(
  parameter int DW = 32,
  parameter int BW = 5
) (
  input  logic [DW-1:0] word,
  input  logic [BW-1:0] bit_sel,
  input  logic          bit_val,
  output logic [DW-1:0] merged,
  output logic          bit_out
);

  always_comb begin
    merged          = word;
    merged[bit_sel] = bit_val;
  end

  assign bit_out = word[bit_sel];

endmodule

// File: rtl/data_word_access_ctrl.sv
// Initiator for the data word RAM port: word load/store plus bit read and bit
// read-modify-write (bit commands only when DMEM_BIT_ACCESS_EN is defined).
//
// state   | meaning
// IDLE    | waiting for REQ
// WR      | memory write cycle (word store or final RMW cycle), DONE high
// RD_A    | read address presented to memory
// RD_D    | read data returned by memory, captured at end of cycle
// RSP     | read result or error reported, DONE high
module data_word_access_ctrl
  import data_word_access_ctrl_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int BW    = $clog2(DW),
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ,
  input  logic [1:0]    CMD,
  input  logic [AW-1:0] ADDR,
  input  logic [BW-1:0] BIT_SEL,
  input  logic [DW-1:0] WDATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [DW-1:0] RDATA,
  output logic          M_WE,
  output logic [AW-1:0] M_A,
  output logic [DW-1:0] M_DI,
  input  logic [DW-1:0] M_DQ
);

  state_e        state, state_nxt;
  logic          done_q, done_nxt;
  logic          err_q, err_nxt;
  logic          we_q, we_nxt;
  logic [AW-1:0] a_q, a_nxt;
  logic [DW-1:0] di_q, di_nxt;
  logic [DW-1:0] rdata_q, rdata_nxt;
  logic          in_range;
  logic          cmd_ok;

  assign in_range = ({1'b0, ADDR} < (AW+1)'(DEPTH));

`ifdef DMEM_BIT_ACCESS_EN
  cmd_e          cmd_q;
  logic [BW-1:0] bit_sel_q;
  logic          bit_val_q;
  logic          latch;
  logic [DW-1:0] merged;
  logic          bit_out;

  assign cmd_ok = 1'b1;

  dmem_bit_merge #(.DW(DW), .BW(BW)) u_merge (
    .word    (M_DQ),
    .bit_sel (bit_sel_q),
    .bit_val (bit_val_q),
    .merged  (merged),
    .bit_out (bit_out)
  );
`else
  logic unused_bit_sel;

  assign cmd_ok         = ~CMD[1];
  assign unused_bit_sel = ^BIT_SEL;
`endif

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    we_nxt    = 1'b0;
    a_nxt     = a_q;
    di_nxt    = di_q;
    rdata_nxt = rdata_q;
`ifdef DMEM_BIT_ACCESS_EN
    latch     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (REQ) begin
`ifdef DMEM_BIT_ACCESS_EN
          latch = 1'b1;
`endif
          if (!in_range || !cmd_ok) begin
            state_nxt = ST_RSP;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
            if (CMD != CMD_WRW) rdata_nxt = '0;
          end else if (CMD == CMD_WRW) begin
            state_nxt = ST_WR;
            we_nxt    = 1'b1;
            a_nxt     = ADDR;
            di_nxt    = WDATA;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_RD_A;
            a_nxt     = ADDR;
          end
        end
      end
      ST_RD_A: state_nxt = ST_RD_D;
      ST_RD_D: begin
        done_nxt = 1'b1;
`ifdef DMEM_BIT_ACCESS_EN
        if (cmd_q == CMD_WRB) begin
          state_nxt = ST_WR;
          we_nxt    = 1'b1;
          di_nxt    = merged;
        end else if (cmd_q == CMD_RDB) begin
          state_nxt = ST_RSP;
          rdata_nxt = {{(DW-1){1'b0}}, bit_out};
        end else begin
          state_nxt = ST_RSP;
          rdata_nxt = M_DQ;
        end
`else
        state_nxt = ST_RSP;
        rdata_nxt = M_DQ;
`endif
      end
      ST_WR, ST_RSP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= '0;
      di_q    <= '0;
      rdata_q <= '0;
`ifdef DMEM_BIT_ACCESS_EN
      cmd_q     <= CMD_RDW;
      bit_sel_q <= '0;
      bit_val_q <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      we_q    <= we_nxt;
      a_q     <= a_nxt;
      di_q    <= di_nxt;
      rdata_q <= rdata_nxt;
`ifdef DMEM_BIT_ACCESS_EN
      if (latch) begin
        cmd_q     <= cmd_e'(CMD);
        bit_sel_q <= BIT_SEL;
        bit_val_q <= WDATA[0];
      end
`endif
    end
  end

  assign BUSY  = (state != ST_IDLE);
  assign DONE  = done_q;
  assign ERR   = err_q;
  assign RDATA = rdata_q;
  assign M_WE  = we_q;
  assign M_A   = a_q;
  assign M_DI  = di_q;

endmodule

// File: tb/tb_data_word_access_ctrl.sv
// Self-checking bench for data_word_access_ctrl with a registered-address
// memory model; bit-access vectors depend on DMEM_BIT_ACCESS_EN.
module tb_data_word_access_ctrl;
  import data_word_access_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic [1:0]  CMD = 2'b00;
  logic [15:0] ADDR = '0;
  logic [4:0]  BIT_SEL = '0;
  logic [31:0] WDATA = '0;
  logic        BUSY, DONE, ERR, M_WE;
  logic [31:0] RDATA, M_DI, M_DQ;
  logic [15:0] M_A;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:4095] = '{default: '0};
  logic [15:0] a_reg = '0;

  always #5 CLK = ~CLK;

  data_word_access_ctrl dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .CMD(CMD), .ADDR(ADDR),
    .BIT_SEL(BIT_SEL), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .RDATA(RDATA), .M_WE(M_WE), .M_A(M_A), .M_DI(M_DI),
    .M_DQ(M_DQ)
  );

  always @(posedge CLK) begin
    a_reg <= M_A;
    if (M_WE && M_A < 16'd4096) mem[M_A[11:0]] <= M_DI;
  end
  assign M_DQ = (a_reg < 16'd4096) ? mem[a_reg[11:0]] : 32'h0;

  typedef struct {
    logic [1:0]  cmd;
    logic [15:0] addr;
    logic [4:0]  bsel;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          wes;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    int wes;
    bit seen;
    @(negedge CLK);
    REQ = 1'b1; CMD = v.cmd; ADDR = v.addr; BIT_SEL = v.bsel; WDATA = v.wdata;
    @(posedge CLK);
    #1 REQ = 1'b0;
    k = 0; wes = 0; seen = 0;
    while (!seen && k < 10) begin
      @(negedge CLK);
      k++;
      if (M_WE) wes++;
      if (DONE) seen = 1;
    end
    chk($sformatf("v%0d_latency", idx), k, v.lat);
    chk($sformatf("v%0d_err", idx), {31'b0, ERR}, {31'b0, v.err});
    chk($sformatf("v%0d_rdata", idx), RDATA, v.rdata);
    @(negedge CLK);
    if (M_WE) wes++;
    chk($sformatf("v%0d_we_cycles", idx), wes, v.wes);
    chk($sformatf("v%0d_idle_after", idx), {30'b0, DONE, BUSY}, 32'h0);
  endtask

  initial begin
    int dcnt, first_k, last_k, wes;
    logic [31:0] held_rdata;

    vecs.push_back('{CMD_WRW, 16'h0010, 5'd0, 32'hDEADBEEF, 1, 1'b0, 32'h0, 1});
    vecs.push_back('{CMD_RDW, 16'h0010, 5'd0, 32'h0, 3, 1'b0, 32'hDEADBEEF, 0});
    vecs.push_back('{CMD_WRW, 16'h0020, 5'd0, 32'h0000000F, 1, 1'b0, 32'hDEADBEEF, 1});
    vecs.push_back('{CMD_RDW, 16'h1000, 5'd0, 32'h0, 1, 1'b1, 32'h0, 0});
    vecs.push_back('{CMD_RDW, 16'h0020, 5'd0, 32'h0, 3, 1'b0, 32'h0000000F, 0});
    vecs.push_back('{CMD_WRW, 16'hFFFF, 5'd0, 32'h12345678, 1, 1'b1, 32'h0000000F, 0});
    vecs.push_back('{CMD_WRW, 16'h0FFF, 5'd0, 32'hA5A5A5A5, 1, 1'b0, 32'h0000000F, 1});
    vecs.push_back('{CMD_RDW, 16'h0FFF, 5'd0, 32'h0, 3, 1'b0, 32'hA5A5A5A5, 0});
`ifdef DMEM_BIT_ACCESS_EN
    vecs.push_back('{CMD_WRB, 16'h0020, 5'd31, 32'h1, 3, 1'b0, 32'hA5A5A5A5, 1});
    vecs.push_back('{CMD_RDW, 16'h0020, 5'd0, 32'h0, 3, 1'b0, 32'h8000000F, 0});
    vecs.push_back('{CMD_RDB, 16'h0020, 5'd3, 32'h0, 3, 1'b0, 32'h1, 0});
    vecs.push_back('{CMD_RDB, 16'h0020, 5'd4, 32'h0, 3, 1'b0, 32'h0, 0});
    vecs.push_back('{CMD_WRB, 16'h0020, 5'd0, 32'hFFFFFFFE, 3, 1'b0, 32'h0, 1});
    vecs.push_back('{CMD_RDW, 16'h0020, 5'd0, 32'h0, 3, 1'b0, 32'h8000000E, 0});
    vecs.push_back('{CMD_RDB, 16'h1000, 5'd0, 32'h0, 1, 1'b1, 32'h0, 0});
`else
    vecs.push_back('{CMD_WRB, 16'h0001, 5'd0, 32'h1, 1, 1'b1, 32'h0, 0});
    vecs.push_back('{CMD_RDW, 16'h0001, 5'd0, 32'h0, 3, 1'b0, 32'h0, 0});
    vecs.push_back('{CMD_RDB, 16'h0020, 5'd3, 32'h0, 1, 1'b1, 32'h0, 0});
    vecs.push_back('{CMD_RDW, 16'h0020, 5'd0, 32'h0, 3, 1'b0, 32'h0000000F, 0});
`endif

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_busy", {31'b0, BUSY}, 32'h0);
    chk("reset_done_err", {30'b0, DONE, ERR}, 32'h0);
    chk("reset_rdata", RDATA, 32'h0);
    chk("reset_we", {31'b0, M_WE}, 32'h0);
    chk("reset_m_a", {16'b0, M_A}, 32'h0);
    chk("reset_m_di", M_DI, 32'h0);
    RST = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);
    chk("mem_10_contents", mem[12'h010], 32'hDEADBEEF);

    // REQ held high: reads accepted once every 4 cycles
    @(negedge CLK);
    REQ = 1'b1; CMD = CMD_RDW; ADDR = 16'h0010;
    dcnt = 0; first_k = 0; last_k = 0; wes = 0; held_rdata = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (M_WE) wes++;
      if (DONE) begin
        dcnt++;
        if (first_k == 0) begin
          first_k = k;
          held_rdata = RDATA;
        end
        last_k = k;
      end
    end
    REQ = 1'b0;
    chk("held_req_done_count", dcnt, 3);
    chk("held_req_first_done", first_k, 3);
    chk("held_req_last_done", last_k, 11);
    chk("held_req_rdata", held_rdata, 32'hDEADBEEF);
    chk("held_req_no_we", wes, 0);
    for (int k = 0; k < 8 && BUSY; k++) @(negedge CLK);
    chk("held_req_drained", {31'b0, BUSY}, 32'h0);

    // Reset during the data cycle of a word read
    @(negedge CLK);
    REQ = 1'b1; CMD = CMD_RDW; ADDR = 16'h0020;
    @(posedge CLK);
    #1 REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_rd_outputs", {29'b0, BUSY, DONE, ERR}, 32'h0);
    chk("abort_rd_rdata", RDATA, 32'h0);
    dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (DONE) dcnt++;
    end
    chk("abort_rd_no_done", dcnt, 0);

`ifdef DMEM_BIT_ACCESS_EN
    // Reset during RD_D of a bit RMW leaves memory untouched
    @(negedge CLK);
    REQ = 1'b1; CMD = CMD_WRB; ADDR = 16'h0005; BIT_SEL = 5'd2; WDATA = 32'h1;
    @(posedge CLK);
    #1 REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_wrb_outputs", {28'b0, BUSY, DONE, ERR, M_WE}, 32'h0);
    chk("abort_wrb_m_a_di", {M_A, M_DI[15:0]}, 32'h0);
    dcnt = 0; wes = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (DONE) dcnt++;
      if (M_WE) wes++;
    end
    chk("abort_wrb_no_done", dcnt, 0);
    chk("abort_wrb_no_we", wes, 0);
    chk("abort_wrb_mem", mem[12'h005], 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
